sym_timing_ctrl: RTL and testbench
==================================

// Module: sym_timing_ctrl
// PURPOSE
//  Symbol-timing scheduler for the polyphase fractional-delay interpolator.
//  - Counts raw I/Q samples and issues one symbol strobe per OSF samples.
//  - Each strobe carries the interpolator controls: phase_int_o (0..OSF-1) and mu_o.
//  - Integrates timing-error corrections from the TED/loop filter.
//  - Handles symbol slips: drops a strobe on overflow, inserts an extra strobe on underflow.
// PARAMETERS
//  OSF      20   raw samples per symbol; phase bank count
//  FRAC_W   27   fraction bits of tau (mu width)
//  MAX_ADJ  1    max |correction| applied per symbol, in whole raw samples
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous, active-low reset
//  en_i         in   1   run enable; 0 forces IDLE
//  iq_raw_val_i in   1   raw sample strobe; all counting is qualified by it
//  err_i        in   32  signed Q5.27 timing correction, in raw samples
//  err_val_i    in   1   err_i valid, single-cycle
//  sym_valid_o  out  1   symbol strobe pulse; drives interpolator sym_valid_i
//  phase_int_o  out  5   integer delay from newest sample (0..OSF-1)
//  mu_o         out  27  fractional delay, Q0.27
//  slip_o       out  1   pulse when a slip occurs
//  slip_dir_o   out  1   slip direction: 1 = skip (strobe dropped), 0 = stuff (strobe added)
// BEHAVIOUR
//  Reset: sym_valid_o=0, slip_o=0, slip_dir_o=0, phase_int_o=OSF/2, mu_o=0.
//    Internal: tau=OSF/2, cnt=0, pend=0, state=IDLE. Reset mid-operation aborts any pending STUFF.
//  tau: unsigned Q5.27 in [0, OSF). phase_int_o=tau[31:27], mu_o=tau[26:0]; both registered.
//  FSM states: IDLE, RUN, STUFF.
//    IDLE -> RUN on en_i=1.
//    Any state -> IDLE on en_i=0. On entry to IDLE: cnt=0, pend=0; tau is held.
//  cnt: counts 0..OSF-1 on iq_raw_val_i and wraps. A strobe event is iq_raw_val_i && cnt==OSF-1.
//  pend: accumulates err_i on each err_val_i, saturating to +-(MAX_ADJ<<27).
//  At a strobe event: t = tau + pend, computed as 34-bit signed; then pend <= 0.
//    If err_val_i coincides with the strobe event, pend <= err_i (saturated); it is not lost.
//    0 <= t < OSF<<27: tau <= t; sym_valid_o pulses 1 cycle later.
//    t >= OSF<<27: tau <= t - (OSF<<27); no strobe; slip_o=1 with slip_dir_o=1.
//    t < 0: tau <= t + (OSF<<27); strobe issued; slip_o=1 with slip_dir_o=0; go to STUFF.
//  STUFF: after OSF/2 further iq_raw_val_i, emit one extra strobe using the current tau; return to RUN.
//    cnt keeps running during STUFF.
//    A regular strobe event inside STUFF is processed normally; the stuffed strobe is still emitted.
//  Latency: sym_valid_o is registered, 1 clk after the qualifying iq_raw_val_i.
//    phase_int_o and mu_o update in that same cycle and hold until the next strobe.
//  sym_valid_o is never asserted in IDLE. At most one pulse per clk.
// CONFIGURATION
//  SYM_TIMING_SLIP_CNT_EN defined:
//    Adds skip_cnt_o[15:0] and stuff_cnt_o[15:0].
//    Each counts slips of its direction, saturating at 16'hFFFF; cleared only by rst_n.
//  Macro undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package msk_timing_pkg holds:
//    - tau_t (logic [31:0]); FRAC_W and ONE = 1<<27 constants
//    - state enum {IDLE, RUN, STUFF}
//    - the sat_add function used for pend
//  Sub-module sym_timing_pend: saturating error accumulator (err_i/err_val_i in; clear on strobe; pend out).
// TESTING
//  1. en_i=1, iq_raw_val_i every clk, no err -> sym_valid_o every 20 clks; phase_int_o=10, mu_o=0.
//  2. One err_i=0x0400_0000 (+0.5) before a strobe -> next strobe phase_int_o=10, mu_o=0x400_0000; period unchanged.
//  3. tau=19.75; err_i=+0.5 -> no strobe that symbol, slip_o=1 with slip_dir_o=1; then phase_int_o=0, mu_o=0x200_0000.
//  4. tau=0.25; err_i=-0.5 -> strobe issued with phase_int_o=19, mu_o=0x600_0000, slip_dir_o=0; extra strobe 10 samples later.
//  5. err_i=+3.0 x3 before a strobe -> pend saturates at +1.0; tau advances by exactly 1.0.
//  6. rst_n=0 during STUFF -> no stuffed strobe; all outputs at reset values next clk.
//     With SYM_TIMING_SLIP_CNT_EN defined, skip_cnt_o and stuff_cnt_o read 0 after the reset.

Source files
------------

// File: rtl/sym_timing_ctrl_pkg.sv
// Shared types and constants for the symbol-timing scheduler.
//   tau_t    : unsigned Q5.27 timing phase (integer phase index + fraction mu)
//   state_t  : scheduler FSM states
//   sat_add  : signed add clamped to +-(MAX_ADJ << FRAC_W), used by the
//              timing-error accumulator
// Optional build macro used by the block: SYM_TIMING_SLIP_CNT_EN

package msk_timing_pkg;

   localparam int OSF     = 20;
   localparam int FRAC_W  = 27;
   localparam int MAX_ADJ = 1;
   localparam int PHASE_W = 5;

   typedef logic [31:0] tau_t;

   localparam tau_t ONE     = tau_t'(1) << FRAC_W;
   localparam tau_t TAU_RST = tau_t'(OSF / 2) << FRAC_W;

   // One symbol period in Q5.27, widened so tau + pend can be compared
   // against it without overflow.
   localparam logic signed [33:0] PERIOD = 34'(OSF) <<< FRAC_W;

   localparam logic signed [32:0] PEND_HI = 33'(MAX_ADJ) <<< FRAC_W;
   localparam logic signed [32:0] PEND_LO = -PEND_HI;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STUFF = 2'd2
   } state_t;

   // a + b with one guard bit, then clamped to the per-symbol correction limit.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      logic signed [32:0] s;
      logic signed [31:0] r;
      s = $signed({a[31], a}) + $signed({b[31], b});
      r = s[31:0];
      if (s > PEND_HI) begin
         r = PEND_HI[31:0];
      end else if (s < PEND_LO) begin
         r = PEND_LO[31:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/sym_timing_ctrl_if.sv
// Bus between the sample front end / timing loop and the symbol-timing
// scheduler.
//   en_i, iq_raw_val_i, err_i, err_val_i        : driven by master
//   sym_valid_o, phase_int_o, mu_o, slip_o,
//   slip_dir_o                                  : driven by slave (scheduler)
//   skip_cnt_o, stuff_cnt_o                     : only with SYM_TIMING_SLIP_CNT_EN
// Modports: master (stimulus/loop side), slave (sym_timing_ctrl).

interface sym_timing_ctrl_if;
   import msk_timing_pkg::*;

   logic                      en_i;
   logic                      iq_raw_val_i;
   logic signed [31:0]        err_i;
   logic                      err_val_i;
   logic                      sym_valid_o;
   logic [PHASE_W-1:0]        phase_int_o;
   logic [FRAC_W-1:0]         mu_o;
   logic                      slip_o;
   logic                      slip_dir_o;
`ifdef SYM_TIMING_SLIP_CNT_EN
   logic [15:0]               skip_cnt_o;
   logic [15:0]               stuff_cnt_o;

   modport master (
      output en_i, iq_raw_val_i, err_i, err_val_i,
      input  sym_valid_o, phase_int_o, mu_o, slip_o, slip_dir_o,
      input  skip_cnt_o, stuff_cnt_o
   );

   modport slave (
      input  en_i, iq_raw_val_i, err_i, err_val_i,
      output sym_valid_o, phase_int_o, mu_o, slip_o, slip_dir_o,
      output skip_cnt_o, stuff_cnt_o
   );
`else
   modport master (
      output en_i, iq_raw_val_i, err_i, err_val_i,
      input  sym_valid_o, phase_int_o, mu_o, slip_o, slip_dir_o
   );

   modport slave (
      input  en_i, iq_raw_val_i, err_i, err_val_i,
      output sym_valid_o, phase_int_o, mu_o, slip_o, slip_dir_o
   );
`endif

endinterface

// File: rtl/sym_timing_ctrl_pend.sv
// sym_timing_pend: saturating accumulator of timing-error corrections
// collected between symbol strobes.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : scheduler not running; hold the accumulator at zero
//   clear        : strobe event consumed the accumulated value
//   err_i        : signed Q5.27 correction
//   err_val_i    : err_i valid, single cycle
//   pend_o       : accumulated correction, limited to +-(MAX_ADJ << 27)

module sym_timing_pend
   import msk_timing_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               clear,
   input  logic signed [31:0] err_i,
   input  logic               err_val_i,
   output logic signed [31:0] pend_o
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_o <= '0;
      end else if (flush) begin
         pend_o <= '0;
      end else if (clear) begin
         // A correction arriving on the strobe cycle starts the next symbol's
         // accumulation instead of being dropped.
         pend_o <= err_val_i ? sat_add(32'sd0, err_i) : '0;
      end else if (err_val_i) begin
         pend_o <= sat_add(pend_o, err_i);
      end
   end

endmodule

// File: rtl/sym_timing_ctrl.sv
// sym_timing_ctrl: symbol-timing scheduler for the polyphase fractional-delay
// interpolator. Counts raw samples, issues one strobe per OSF samples carrying
// the interpolator phase (phase_int_o) and fraction (mu_o), folds in TED/loop
// corrections once per symbol, and handles symbol slips (drop on overflow,
// extra strobe on underflow).
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : sym_timing_ctrl_if.slave (enable, raw sample strobe, error input,
//           strobe/phase/mu/slip outputs)
// Build macro SYM_TIMING_SLIP_CNT_EN adds saturating skip/stuff slip counters
// on the bus; without it the counters do not exist.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | disabled; sample count and pending correction held at zero
// RUN   | counting samples, strobe every OSF samples
// STUFF | underflow seen; extra strobe due OSF/2 samples after the slip

module sym_timing_ctrl
   import msk_timing_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   sym_timing_ctrl_if.slave  bus
);

   localparam logic [4:0] CNT_LAST   = 5'(OSF - 1);
   localparam logic [3:0] STUFF_WAIT = 4'(OSF / 2);

   state_t             state;
   logic [4:0]         cnt;
   logic [3:0]         stuff_left;
   tau_t               tau;
   logic signed [31:0] pend;

   logic               run;
   logic               flush;
   logic               strobe_evt;
   logic               stuff_fire;
   logic signed [33:0] t;
   logic               over;
   logic               under;
   tau_t               tau_hi;
   tau_t               tau_lo;

   assign run        = bus.en_i && (state != IDLE);
   assign flush      = !run;
   assign strobe_evt = run && bus.iq_raw_val_i && (cnt == CNT_LAST);
   assign stuff_fire = run && (state == STUFF) && bus.iq_raw_val_i &&
                       (stuff_left == 4'd1);

   assign t     = $signed({2'b00, tau}) + $signed({{2{pend[31]}}, pend});
   assign over  = (t >= PERIOD);
   assign under = t[33];

   // |pend| <= 1 sample keeps t within one period of [0, OSF), so the
   // wrapped value fits in 32 bits and modular arithmetic is exact.
   assign tau_hi = t[31:0] - PERIOD[31:0];
   assign tau_lo = t[31:0] + PERIOD[31:0];

   sym_timing_pend u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .clear     (strobe_evt),
      .err_i     (bus.err_i),
      .err_val_i (bus.err_val_i),
      .pend_o    (pend)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         stuff_left      <= '0;
         tau             <= TAU_RST;
         bus.sym_valid_o <= 1'b0;
         bus.slip_o      <= 1'b0;
         bus.slip_dir_o  <= 1'b0;
         bus.phase_int_o <= TAU_RST[31:27];
         bus.mu_o        <= '0;
      end else begin
         bus.sym_valid_o <= 1'b0;
         bus.slip_o      <= 1'b0;
         if (!bus.en_i) begin
            state      <= IDLE;
            cnt        <= '0;
            stuff_left <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= RUN;
               end
               RUN, STUFF: begin
                  if (bus.iq_raw_val_i) begin
                     cnt <= (cnt == CNT_LAST) ? '0 : cnt + 5'd1;
                  end
                  if ((state == STUFF) && bus.iq_raw_val_i) begin
                     stuff_left <= stuff_left - 4'd1;
                  end

                  // The stuffed strobe lands mid-symbol (OSF/2 after a regular
                  // event), so it never shares a cycle with a regular strobe.
                  if (stuff_fire) begin
                     bus.sym_valid_o <= 1'b1;
                     bus.phase_int_o <= tau[31:27];
                     bus.mu_o        <= tau[26:0];
                     state           <= RUN;
                  end

                  if (strobe_evt) begin
                     if (over) begin
                        tau            <= tau_hi;
                        bus.slip_o     <= 1'b1;
                        bus.slip_dir_o <= 1'b1;
                     end else if (under) begin
                        tau             <= tau_lo;
                        bus.sym_valid_o <= 1'b1;
                        bus.phase_int_o <= tau_lo[31:27];
                        bus.mu_o        <= tau_lo[26:0];
                        bus.slip_o      <= 1'b1;
                        bus.slip_dir_o  <= 1'b0;
                        state           <= STUFF;
                        stuff_left      <= STUFF_WAIT;
                     end else begin
                        tau             <= t[31:0];
                        bus.sym_valid_o <= 1'b1;
                        bus.phase_int_o <= t[31:27];
                        bus.mu_o        <= t[26:0];
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef SYM_TIMING_SLIP_CNT_EN
   // Slip statistics survive disable; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.skip_cnt_o  <= '0;
         bus.stuff_cnt_o <= '0;
      end else if (strobe_evt) begin
         if (over && (bus.skip_cnt_o != 16'hFFFF)) begin
            bus.skip_cnt_o <= bus.skip_cnt_o + 16'd1;
         end
         if (under && (bus.stuff_cnt_o != 16'hFFFF)) begin
            bus.stuff_cnt_o <= bus.stuff_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sym_timing_ctrl.sv
// Directed bench for sym_timing_ctrl. Raw samples arrive every clock while
// enabled; tau is steered with known corrections so every expected phase/mu
// value and strobe spacing is hand-computed.

module tb_sym_timing_ctrl;
   import msk_timing_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sym_timing_ctrl_if bus ();

   sym_timing_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until a strobe or slip is visible, at most budget cycles.
   task automatic wait_evt(input int budget, output int n, output logic got);
      n   = 0;
      got = 1'b0;
      while (!got && (n < budget)) begin
         step();
         n++;
         if (bus.sym_valid_o || bus.slip_o) got = 1'b1;
      end
   endtask

   task automatic pulse_err(input logic [31:0] v);
      bus.err_i     = v;
      bus.err_val_i = 1'b1;
      step();
      bus.err_val_i = 1'b0;
      bus.err_i     = '0;
   endtask

   task automatic test_reset();
      rst_n            = 1'b0;
      bus.en_i         = 1'b0;
      bus.iq_raw_val_i = 1'b0;
      bus.err_i        = '0;
      bus.err_val_i    = 1'b0;
      repeat (3) step();
      total++; if (bus.sym_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.sym_valid_o); end
      total++; if (bus.slip_o !== 1'b0) begin bad++; $display("FAIL rst_slip got=%b want=0", bus.slip_o); end
      total++; if (bus.slip_dir_o !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b want=0", bus.slip_dir_o); end
      total++; if (bus.phase_int_o !== 5'd10) begin bad++; $display("FAIL rst_phase got=%0d want=10", bus.phase_int_o); end
      total++; if (bus.mu_o !== 27'h0) begin bad++; $display("FAIL rst_mu got=%h want=0", bus.mu_o); end
`ifdef SYM_TIMING_SLIP_CNT_EN
      total++; if (bus.skip_cnt_o !== 16'd0 || bus.stuff_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", bus.skip_cnt_o, bus.stuff_cnt_o); end
`endif
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      int   n;
      logic got;
      bus.en_i         = 1'b1;
      bus.iq_raw_val_i = 1'b1;
      wait_evt(40, n, got);
      total++; if (!got || n != 21) begin bad++; $display("FAIL nom_first got=%0d want=21", n); end
      total++; if (bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b0) begin bad++; $display("FAIL nom_flags got=%b%b want=10", bus.sym_valid_o, bus.slip_o); end
      total++; if (bus.phase_int_o !== 5'd10 || bus.mu_o !== 27'h0) begin bad++; $display("FAIL nom_phase got=%0d/%h want=10/0", bus.phase_int_o, bus.mu_o); end
      step();
      total++; if (bus.sym_valid_o !== 1'b0) begin bad++; $display("FAIL nom_pulse_width got=%b want=0", bus.sym_valid_o); end
      wait_evt(40, n, got);
      total++; if (!got || n != 19 || bus.sym_valid_o !== 1'b1) begin bad++; $display("FAIL nom_period got=%0d want=19", n); end
   endtask

   task automatic test_err_half();
      int   n;
      logic got;
      pulse_err(32'h0400_0000);
      wait_evt(40, n, got);
      total++; if (!got || n != 19 || bus.sym_valid_o !== 1'b1) begin bad++; $display("FAIL half_period got=%0d want=19", n); end
      total++; if (bus.phase_int_o !== 5'd10 || bus.mu_o !== 27'h400_0000) begin bad++; $display("FAIL half_phase got=%0d/%h want=10/4000000", bus.phase_int_o, bus.mu_o); end
   endtask

   task automatic test_saturation();
      int   n;
      logic got;
      repeat (3) pulse_err(32'h1800_0000);
      wait_evt(40, n, got);
      total++; if (!got || n != 17 || bus.sym_valid_o !== 1'b1) begin bad++; $display("FAIL sat_period got=%0d want=17", n); end
      total++; if (bus.phase_int_o !== 5'd11 || bus.mu_o !== 27'h400_0000) begin bad++; $display("FAIL sat_phase got=%0d/%h want=11/4000000", bus.phase_int_o, bus.mu_o); end
   endtask

   task automatic test_err_on_strobe();
      int   n;
      int   seen;
      logic got;
      seen = 0;
      repeat (19) begin
         step();
         if (bus.sym_valid_o) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL coin_early got=%0d want=0", seen); end
      bus.err_i     = 32'h0800_0000;
      bus.err_val_i = 1'b1;
      step();
      bus.err_val_i = 1'b0;
      bus.err_i     = '0;
      total++; if (bus.sym_valid_o !== 1'b1 || bus.phase_int_o !== 5'd11 || bus.mu_o !== 27'h400_0000) begin bad++; $display("FAIL coin_strobe got=%b %0d/%h want=1 11/4000000", bus.sym_valid_o, bus.phase_int_o, bus.mu_o); end
      wait_evt(40, n, got);
      total++; if (!got || n != 20 || bus.phase_int_o !== 5'd12 || bus.mu_o !== 27'h400_0000) begin bad++; $display("FAIL coin_next got=%0d %0d/%h want=20 12/4000000", n, bus.phase_int_o, bus.mu_o); end
   endtask

   // tau 12.5 -> 19.75 in bounded steps.
   task automatic test_ramp();
      int   n;
      logic got;
      for (int i = 0; i < 7; i++) begin
         pulse_err(32'h0800_0000);
         wait_evt(40, n, got);
         total++; if (!got || n != 19 || bus.phase_int_o !== 5'(13 + i)) begin bad++; $display("FAIL ramp_%0d got=%0d ph=%0d want=19 ph=%0d", i, n, bus.phase_int_o, 13 + i); end
      end
      pulse_err(32'h0200_0000);
      wait_evt(40, n, got);
      total++; if (!got || bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL ramp_end got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
   endtask

   task automatic test_skip();
      int   n;
      logic got;
      pulse_err(32'h0400_0000);
      wait_evt(40, n, got);
      total++; if (!got || n != 19) begin bad++; $display("FAIL skip_time got=%0d want=19", n); end
      total++; if (bus.slip_o !== 1'b1 || bus.slip_dir_o !== 1'b1 || bus.sym_valid_o !== 1'b0) begin bad++; $display("FAIL skip_flags got=%b%b%b want=110", bus.slip_o, bus.slip_dir_o, bus.sym_valid_o); end
      total++; if (bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL skip_hold got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
      wait_evt(40, n, got);
      total++; if (!got || n != 20 || bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b0) begin bad++; $display("FAIL skip_next got=%0d v=%b s=%b want=20 1 0", n, bus.sym_valid_o, bus.slip_o); end
      total++; if (bus.phase_int_o !== 5'd0 || bus.mu_o !== 27'h200_0000) begin bad++; $display("FAIL skip_phase got=%0d/%h want=0/2000000", bus.phase_int_o, bus.mu_o); end
   endtask

   task automatic test_stuff();
      int   n;
      logic got;
      pulse_err(32'hFC00_0000);
      wait_evt(40, n, got);
      total++; if (!got || n != 19 || bus.sym_valid_o !== 1'b1) begin bad++; $display("FAIL stuff_time got=%0d want=19", n); end
      total++; if (bus.slip_o !== 1'b1 || bus.slip_dir_o !== 1'b0) begin bad++; $display("FAIL stuff_flags got=%b%b want=10", bus.slip_o, bus.slip_dir_o); end
      total++; if (bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL stuff_phase got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
      wait_evt(40, n, got);
      total++; if (!got || n != 10 || bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b0) begin bad++; $display("FAIL stuff_extra got=%0d want=10", n); end
      total++; if (bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL stuff_extra_phase got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
      wait_evt(40, n, got);
      total++; if (!got || n != 10 || bus.sym_valid_o !== 1'b1) begin bad++; $display("FAIL stuff_regular got=%0d want=10", n); end
`ifdef SYM_TIMING_SLIP_CNT_EN
      total++; if (bus.skip_cnt_o !== 16'd1 || bus.stuff_cnt_o !== 16'd1) begin bad++; $display("FAIL slip_cnt got=%0d/%0d want=1/1", bus.skip_cnt_o, bus.stuff_cnt_o); end
`endif
   endtask

   task automatic test_disable();
      int   n;
      int   seen;
      logic got;
      pulse_err(32'h0400_0000);
      bus.en_i = 1'b0;
      seen = 0;
      repeat (30) begin
         step();
         if (bus.sym_valid_o || bus.slip_o) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL idle_strobe got=%0d want=0", seen); end
      bus.en_i = 1'b1;
      wait_evt(40, n, got);
      total++; if (!got || n != 21 || bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b0) begin bad++; $display("FAIL reen_first got=%0d v=%b s=%b want=21 1 0", n, bus.sym_valid_o, bus.slip_o); end
      total++; if (bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL reen_phase got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
   endtask

   task automatic test_reset_in_stuff();
      int   n;
      logic got;
      pulse_err(32'h0800_0000);
      wait_evt(40, n, got);
      total++; if (!got || bus.slip_o !== 1'b1 || bus.slip_dir_o !== 1'b1) begin bad++; $display("FAIL rs_skip got=%b%b want=11", bus.slip_o, bus.slip_dir_o); end
      pulse_err(32'hF800_0000);
      wait_evt(40, n, got);
      total++; if (!got || bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b1 || bus.slip_dir_o !== 1'b0) begin bad++; $display("FAIL rs_stuff got=%b%b%b want=110", bus.sym_valid_o, bus.slip_o, bus.slip_dir_o); end
      total++; if (bus.phase_int_o !== 5'd19 || bus.mu_o !== 27'h600_0000) begin bad++; $display("FAIL rs_stuff_phase got=%0d/%h want=19/6000000", bus.phase_int_o, bus.mu_o); end
      repeat (3) step();
      rst_n = 1'b0;
      step();
      total++; if (bus.sym_valid_o !== 1'b0 || bus.slip_o !== 1'b0 || bus.slip_dir_o !== 1'b0) begin bad++; $display("FAIL rs_flags got=%b%b%b want=000", bus.sym_valid_o, bus.slip_o, bus.slip_dir_o); end
      total++; if (bus.phase_int_o !== 5'd10 || bus.mu_o !== 27'h0) begin bad++; $display("FAIL rs_phase got=%0d/%h want=10/0", bus.phase_int_o, bus.mu_o); end
`ifdef SYM_TIMING_SLIP_CNT_EN
      total++; if (bus.skip_cnt_o !== 16'd0 || bus.stuff_cnt_o !== 16'd0) begin bad++; $display("FAIL rs_cnt got=%0d/%0d want=0/0", bus.skip_cnt_o, bus.stuff_cnt_o); end
`endif
      rst_n = 1'b1;
      wait_evt(40, n, got);
      total++; if (!got || n != 21 || bus.sym_valid_o !== 1'b1 || bus.slip_o !== 1'b0) begin bad++; $display("FAIL rs_after got=%0d v=%b s=%b want=21 1 0", n, bus.sym_valid_o, bus.slip_o); end
      total++; if (bus.phase_int_o !== 5'd10 || bus.mu_o !== 27'h0) begin bad++; $display("FAIL rs_after_phase got=%0d/%h want=10/0", bus.phase_int_o, bus.mu_o); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_nominal();
      test_err_half();
      test_saturation();
      test_err_on_strobe();
      test_ramp();
      test_skip();
      test_stuff();
      test_disable();
      test_reset_in_stuff();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
